p2_link_rx: RTL and testbench

P2_LINK_RX -- requirements
Module: p2_link_rx

---
 rtl/p2_link_rx.sv | 99 +++++++++
 tb/tb_p2_link_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p2_link_rx.sv
// p2_link_rx: receive end of the 3-byte peer link frame {HEADER, P, P^HEADER}.
// Pops bytes from a UART RX FIFO, validates each frame, publishes the payload
// and tracks link health plus a saturating checksum error count.
// Optional feature: define P2_LINK_TIMEOUT_EN to build the link-loss watchdog.
// Without it, link_ok rises on the first good frame and stays high until reset.
module p2_link_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 6500000,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic [7:0] p2_data,
    output logic       p2_data_valid,
    output logic       link_ok,
    output logic [7:0] frame_err_cnt
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cand;
    logic       good_c;

`ifdef P2_LINK_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd;
`endif

    // Pop whenever a byte is available; never while held in reset.
    assign rd_uart = rst & ~rx_empty;

    // A checksum byte that matches the latched candidate payload.
    assign good_c = rd_uart && (state == CHECK) && (r_data == (cand ^ HEADER));

    // Frame decoder, output registers and (optionally) the link watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= HUNT;
            cand          <= 8'h00;
            p2_data       <= 8'h00;
            p2_data_valid <= 1'b0;
            link_ok       <= 1'b0;
            frame_err_cnt <= 8'h00;
`ifdef P2_LINK_TIMEOUT_EN
            wd            <= '0;
`endif
        end else begin
            p2_data_valid <= 1'b0;
            if (rd_uart) begin
                case (state)
                    HUNT: begin
                        if (r_data == HEADER) state <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        cand  <= r_data;
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (good_c) begin
                            p2_data       <= cand;
                            p2_data_valid <= 1'b1;
                            link_ok       <= 1'b1;
                            state         <= HUNT;
                        end else begin
                            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                            // A bad checksum that is itself a header starts the next frame.
                            state <= (r_data == HEADER) ? PAYLOAD : HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
`ifdef P2_LINK_TIMEOUT_EN
            // Count cycles since the last good frame; drop the link when the count hits the limit.
            if (good_c) begin
                wd <= '0;
            end else if (link_ok) begin
                if (wd >= WD_LAST) begin
                    wd      <= WD_MAX;
                    link_ok <= 1'b0;
                    p2_data <= 8'h00;
                end else begin
                    wd <= wd + WD_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_p2_link_rx.sv
// Self-checking bench for p2_link_rx: directed vector table, hand-written
// reset/saturation/timeout sequences, and randomized bytes against a
// queue-based frame model.
module tb_p2_link_rx;

    localparam int unsigned T   = 100;
    localparam logic [7:0]  HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic [7:0] p2_data;
    logic       p2_data_valid;
    logic       link_ok;
    logic [7:0] frame_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    p2_link_rx #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_empty     (rx_empty),
        .r_data       (r_data),
        .rd_uart      (rd_uart),
        .p2_data      (p2_data),
        .p2_data_valid(p2_data_valid),
        .link_ok      (link_ok),
        .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic [7:0] d;
        logic       v;
        logic [7:0] data;
        logic       link;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[$];

    // Reference model: bytes of the frame collected so far.
    logic [7:0] mq[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_link;
    int         m_err;
    int         m_since;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_link  = 1'b0;
        m_err   = 0;
        m_since = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] d);
        logic good;
        good    = 1'b0;
        m_valid = 1'b0;
        if (!e) begin
            if (mq.size() == 0) begin
                if (d == HDR) mq.push_back(d);
            end else if (mq.size() == 1) begin
                mq.push_back(d);
            end else begin
                if (d == (mq[1] ^ HDR)) begin
                    good    = 1'b1;
                    m_data  = mq[1];
                    m_valid = 1'b1;
                    m_link  = 1'b1;
                    mq.delete();
                end else begin
                    if (m_err < 255) m_err++;
                    mq.delete();
                    if (d == HDR) mq.push_back(d);
                end
            end
        end
`ifdef P2_LINK_TIMEOUT_EN
        if (good) begin
            m_since = 0;
        end else if (m_link) begin
            m_since++;
            if (m_since >= T) begin
                m_link = 1'b0;
                m_data = 8'h00;
            end
        end
`endif
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Present one cycle of input, check the pop strobe, then advance past the edge.
    task automatic drive(input logic e, input logic [7:0] d);
        rx_empty = e;
        r_data   = d;
        #1;
        chk("rd_uart", 32'(rd_uart), 32'(!e));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [7:0] data,
                            input logic link, input logic [7:0] err);
        chk({tag, ".valid"}, 32'(p2_data_valid), 32'(v));
        chk({tag, ".data"},  32'(p2_data),       32'(data));
        chk({tag, ".link"},  32'(link_ok),       32'(link));
        chk({tag, ".err"},   32'(frame_err_cnt), 32'(err));
    endtask

    function automatic vec_t mk(input logic e, input logic [7:0] d, input logic v,
                                input logic [7:0] data, input logic link, input logic [7:0] err);
        vec_t r;
        r.e = e; r.d = d; r.v = v; r.data = data; r.link = link; r.err = err;
        return r;
    endfunction

    initial begin
        // Directed vector table, applied back to back from reset.
        tbl.push_back(mk(0, 8'hA5, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h3C, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h99, 1, 8'h3C, 1, 0));   // good frame
        tbl.push_back(mk(1, 8'h00, 0, 8'h3C, 1, 0));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h3C, 1, 0));
        tbl.push_back(mk(0, 8'h3C, 0, 8'h3C, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'h3C, 1, 1));   // bad checksum
        tbl.push_back(mk(0, 8'h11, 0, 8'h3C, 1, 1));   // garbage, not counted
        tbl.push_back(mk(0, 8'h22, 0, 8'h3C, 1, 1));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h3C, 1, 1));
        tbl.push_back(mk(0, 8'h05, 0, 8'h3C, 1, 1));
        tbl.push_back(mk(0, 8'hA0, 1, 8'h05, 1, 1));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h05, 1, 1));
        tbl.push_back(mk(0, 8'h10, 0, 8'h05, 1, 1));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h05, 1, 2));   // bad checksum that resyncs
        tbl.push_back(mk(0, 8'h07, 0, 8'h05, 1, 2));
        tbl.push_back(mk(0, 8'hA2, 1, 8'h07, 1, 2));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h07, 1, 2));
        tbl.push_back(mk(0, 8'hA5, 0, 8'h07, 1, 2));   // header-valued payload
        tbl.push_back(mk(0, 8'h00, 1, 8'hA5, 1, 2));
        tbl.push_back(mk(0, 8'hA5, 0, 8'hA5, 1, 2));
        tbl.push_back(mk(1, 8'h5A, 0, 8'hA5, 1, 2));   // stalls inside a frame
        tbl.push_back(mk(0, 8'h42, 0, 8'hA5, 1, 2));
        tbl.push_back(mk(1, 8'hE7, 0, 8'hA5, 1, 2));
        tbl.push_back(mk(0, 8'hE7, 1, 8'h42, 1, 2));
        tbl.push_back(mk(1, 8'h00, 0, 8'h42, 1, 2));

        do_reset();
        #1;
        chk_outs("reset", 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].e, tbl[i].d);
            chk_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].data, tbl[i].link, tbl[i].err);
        end

        // Async reset in the middle of a frame discards it.
        do_reset();
        drive(1'b0, 8'hA5);
        rx_empty = 1'b0;
        r_data   = 8'h3C;
        #2 rst = 1'b0;
        #1;
        chk("rst_rd_uart", 32'(rd_uart), 32'(0));
        chk_outs("async_rst", 1'b0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 8'h3C);
        chk_outs("post_rst_p", 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b0, 8'h99);
        chk_outs("post_rst_c", 1'b0, 8'h00, 1'b0, 8'h00);

        // 300 bad frames saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 8'hA5);
            drive(1'b0, 8'h00);
            drive(1'b0, 8'h00);
            if (i == 253) chk("err254", 32'(frame_err_cnt), 32'(254));
        end
        chk_outs("saturate", 1'b0, 8'h00, 1'b0, 8'hFF);

`ifdef P2_LINK_TIMEOUT_EN
        // Watchdog: link drops exactly TIMEOUT cycles after the last good frame.
        do_reset();
        drive(1'b0, 8'hA5);
        drive(1'b0, 8'h3C);
        drive(1'b0, 8'h99);
        chk_outs("to_good", 1'b1, 8'h3C, 1'b1, 8'h00);
        for (int i = 1; i <= T; i++) begin
            drive(1'b1, 8'h00);
            if (i == T - 1) chk_outs("to_before", 1'b0, 8'h3C, 1'b1, 8'h00);
        end
        chk_outs("to_lost", 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (5) drive(1'b1, 8'h00);
        chk_outs("to_hold", 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b0, 8'hA5);
        drive(1'b0, 8'h12);
        drive(1'b0, 8'hB7);
        chk_outs("to_restore", 1'b1, 8'h12, 1'b1, 8'h00);
`endif

        // Randomized bytes against the frame model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic       e;
            logic [7:0] d;
            int         pick;
            e    = ($urandom_range(0, 99) < 25);
            pick = $urandom_range(0, 99);
            if (pick < 35)                            d = HDR;
            else if (pick < 75 && mq.size() == 2)     d = mq[1] ^ HDR;
            else                                      d = 8'($urandom);
            model_step(e, d);
            drive(e, d);
            chk_outs("rand", m_valid, m_data, m_link, 8'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
